// File: rtl/stream_frame_gen_pkg.sv
// Shared types and constants for the frame streamer: FSM encoding, sideband
// flag positions and beat-width helpers.
package stream_frame_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_GAP   = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    // Sideband flags ride above the channel data inside a FIFO beat
    localparam int FLAG_W  = 3;
    localparam int SOF_BIT = 0;
    localparam int EOL_BIT = 1;
    localparam int EOF_BIT = 2;

    function automatic int beat_width(input int data_width, input int num_ch);
        return data_width * num_ch + FLAG_W;
    endfunction

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/skid_fifo2.sv
// Two-entry registered FIFO with a valid/ready output handshake; the head
// entry drives the output directly so data is stable while stalled.
module skid_fifo2 #(
    parameter int W = 67
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         ready,
    output logic         valid,
    output logic [W-1:0] head_data,
    output logic [1:0]   count
);

    logic [W-1:0] head_r;
    logic [W-1:0] tail_r;
    logic [W-1:0] head_s;
    logic [W-1:0] tail_s;
    logic [1:0]   count_r;
    logic [1:0]   count_s;
    logic         valid_r;
    logic         pop_s;
    logic         push_s;

    // Next storage contents for every push/pop combination
    always_comb begin
        pop_s   = valid_r && ready;
        push_s  = push && ((count_r != 2'd2) || pop_s);
        head_s  = head_r;
        tail_s  = tail_r;
        count_s = count_r;
        case ({push_s, pop_s})
            2'b10: begin
                if (count_r == 2'd0) begin
                    head_s = push_data;
                end else begin
                    tail_s = push_data;
                end
                count_s = count_r + 2'd1;
            end
            2'b01: begin
                head_s  = tail_r;
                count_s = count_r - 2'd1;
            end
            2'b11: begin
                if (count_r == 2'd1) begin
                    head_s = push_data;
                end else begin
                    head_s = tail_r;
                    tail_s = push_data;
                end
            end
            default: begin
                count_s = count_r;
            end
        endcase
    end

    // Storage and occupancy registers
    always_ff @(posedge clk) begin
        if (reset) begin
            head_r  <= '0;
            tail_r  <= '0;
            count_r <= 2'd0;
            valid_r <= 1'b0;
        end else begin
            head_r  <= head_s;
            tail_r  <= tail_s;
            count_r <= count_s;
            valid_r <= (count_s != 2'd0);
        end
    end

    assign valid     = valid_r;
    assign head_data = head_r;
    assign count     = count_r;

endmodule

// File: rtl/stream_frame_gen.sv
// Multi-channel raster frame streamer: reads NUM_CH channels per pixel from a
// 1-cycle-latency buffer and replays every frame NUM_PASS times with markers.
module stream_frame_gen
    import stream_frame_gen_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_CH     = 8,
    parameter int WIDTH      = 56,
    parameter int HEIGHT     = 56,
    parameter int NUM_IMG    = 1,
    parameter int NUM_PASS   = 3,
    parameter int GAP        = 0,
    parameter int ADDR_WIDTH = $clog2(WIDTH * HEIGHT * NUM_IMG)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    output logic                         mem_rd_en,
    output logic [ADDR_WIDTH-1:0]        mem_addr,
    input  logic [NUM_CH*DATA_WIDTH-1:0] mem_rdata,
    output logic [NUM_CH*DATA_WIDTH-1:0] data_out,
    output logic                         valid_out,
    input  logic                         ready_in,
    output logic                         sof,
    output logic                         eol,
    output logic                         eof,
    output logic                         busy,
    output logic                         done
);

    localparam int DW     = NUM_CH * DATA_WIDTH;
    localparam int BW     = beat_width(DATA_WIDTH, NUM_CH);
    localparam int COL_W  = cnt_width(WIDTH);
    localparam int ROW_W  = cnt_width(HEIGHT);
    localparam int IMG_W  = cnt_width(NUM_IMG);
    localparam int PASS_W = cnt_width(NUM_PASS);

    state_t                state_r;
    state_t                state_s;
    logic [COL_W-1:0]      col_r;
    logic [COL_W-1:0]      col_s;
    logic [ROW_W-1:0]      row_r;
    logic [ROW_W-1:0]      row_s;
    logic [IMG_W-1:0]      img_r;
    logic [IMG_W-1:0]      img_s;
    logic [PASS_W-1:0]     pass_r;
    logic [PASS_W-1:0]     pass_s;
    logic [ADDR_WIDTH-1:0] addr_r;
    logic [ADDR_WIDTH-1:0] addr_s;
    logic [7:0]            gap_cnt_r;
    logic                  in_flight_r;
    logic [FLAG_W-1:0]     flags_r;
    logic [FLAG_W-1:0]     flags_s;
    logic                  busy_r;
    logic                  busy_s;
    logic                  done_r;
    logic                  done_s;

    logic                  last_col_s;
    logic                  last_row_s;
    logic                  last_img_s;
    logic                  last_pass_s;
    logic                  frame_end_s;
    logic                  run_end_s;
    logic                  issue_s;
    logic                  credit_ok_s;
    logic                  xfer_s;
    logic                  drain_empty_s;
    logic [2:0]            credits_s;

    logic [BW-1:0]         head_s;
    logic [1:0]            fifo_count_s;
    logic                  fifo_valid_s;

    // Position, credit and issue decisions for the current cycle
    always_comb begin
        last_col_s  = (col_r == COL_W'(WIDTH - 1));
        last_row_s  = (row_r == ROW_W'(HEIGHT - 1));
        last_img_s  = (img_r == IMG_W'(NUM_IMG - 1));
        last_pass_s = (pass_r == PASS_W'(NUM_PASS - 1));
        xfer_s      = fifo_valid_s && ready_in;
        // Buffered beats plus the read whose data lands this cycle
        credits_s   = {1'b0, fifo_count_s} + {2'b00, in_flight_r};
        credit_ok_s = (credits_s <= 3'd1) || ((credits_s == 3'd2) && xfer_s);
        issue_s     = (state_r == ST_RUN) && credit_ok_s;
        frame_end_s = issue_s && last_col_s && last_row_s;
        run_end_s   = frame_end_s && last_img_s && last_pass_s;
        drain_empty_s = !in_flight_r &&
                        ((fifo_count_s == 2'd0) || ((fifo_count_s == 2'd1) && xfer_s));
        flags_s          = '0;
        flags_s[SOF_BIT] = (col_r == '0) && (row_r == '0);
        flags_s[EOL_BIT] = last_col_s;
        flags_s[EOF_BIT] = last_col_s && last_row_s;
    end

    // Raster counters; the linear address follows col/row/img and restarts each pass
    always_comb begin
        col_s  = col_r;
        row_s  = row_r;
        img_s  = img_r;
        pass_s = pass_r;
        addr_s = addr_r;
        if (state_r == ST_IDLE) begin
            col_s  = '0;
            row_s  = '0;
            img_s  = '0;
            pass_s = '0;
            addr_s = '0;
        end else if (issue_s) begin
            addr_s = addr_r + ADDR_WIDTH'(1);
            if (last_col_s) begin
                col_s = '0;
                if (last_row_s) begin
                    row_s = '0;
                    if (last_img_s) begin
                        img_s  = '0;
                        addr_s = '0;
                        if (last_pass_s) begin
                            pass_s = '0;
                        end else begin
                            pass_s = pass_r + PASS_W'(1);
                        end
                    end else begin
                        img_s = img_r + IMG_W'(1);
                    end
                end else begin
                    row_s = row_r + ROW_W'(1);
                end
            end else begin
                col_s = col_r + COL_W'(1);
            end
        end else begin
            addr_s = addr_r;
        end
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_s = ST_RUN;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (run_end_s) begin
                    state_s = ST_DRAIN;
                end else if (frame_end_s && (GAP > 0)) begin
                    state_s = ST_GAP;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_GAP: begin
                if (gap_cnt_r == 8'(GAP - 1)) begin
                    state_s = ST_RUN;
                end else begin
                    state_s = ST_GAP;
                end
            end
            ST_DRAIN: begin
                if (drain_empty_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_DRAIN;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Status outputs, looking ahead one edge so they register with the state change
    always_comb begin
        busy_s = (state_s != ST_IDLE);
        done_s = (state_r == ST_DRAIN) && (state_s == ST_IDLE);
    end

    // State, counters, read pipeline and status registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            col_r       <= '0;
            row_r       <= '0;
            img_r       <= '0;
            pass_r      <= '0;
            addr_r      <= '0;
            gap_cnt_r   <= 8'd0;
            in_flight_r <= 1'b0;
            flags_r     <= '0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            col_r       <= col_s;
            row_r       <= row_s;
            img_r       <= img_s;
            pass_r      <= pass_s;
            addr_r      <= addr_s;
            gap_cnt_r   <= (state_r == ST_GAP) ? (gap_cnt_r + 8'd1) : 8'd0;
            in_flight_r <= issue_s;
            flags_r     <= flags_s;
            busy_r      <= busy_s;
            done_r      <= done_s;
        end
    end

    skid_fifo2 #(
        .W (BW)
    ) u_out_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (in_flight_r),
        .push_data ({flags_r, mem_rdata}),
        .ready     (ready_in),
        .valid     (fifo_valid_s),
        .head_data (head_s),
        .count     (fifo_count_s)
    );

    assign mem_rd_en = issue_s;
    assign mem_addr  = addr_r;
    assign data_out  = head_s[DW-1:0];
    assign valid_out = fifo_valid_s;
    assign sof       = head_s[DW + SOF_BIT];
    assign eol       = head_s[DW + EOL_BIT];
    assign eof       = head_s[DW + EOF_BIT];
    assign busy      = busy_r;
    assign done      = done_r;

endmodule

// File: tb/tb_stream_frame_gen.sv
// Directed self-checking bench for stream_frame_gen: 4x4 frames, two images,
// two passes, three-cycle gaps, with backpressure, mid-run reset and restart.
module tb_stream_frame_gen;

    localparam int DW       = 32;
    localparam int NCH      = 2;
    localparam int W        = 4;
    localparam int H        = 4;
    localparam int NIMG     = 2;
    localparam int NPASS    = 2;
    localparam int GAPC     = 3;
    localparam int AW       = 5;
    localparam int FRAME    = W * H;
    localparam int PASS_PIX = FRAME * NIMG;
    localparam int TOTAL    = PASS_PIX * NPASS;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic              mem_rd_en;
    logic [AW-1:0]     mem_addr;
    logic [NCH*DW-1:0] mem_rdata = '0;
    logic [NCH*DW-1:0] data_out;
    logic              valid_out;
    logic              ready_in;
    logic              sof;
    logic              eol;
    logic              eof;
    logic              busy;
    logic              done;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // Buffer memory model: word = {addr+100, addr}, one cycle read latency
    always @(posedge clk) begin
        if (mem_rd_en) begin
            mem_rdata <= {32'(mem_addr) + 32'd100, 32'(mem_addr)};
        end
    end

    stream_frame_gen #(
        .DATA_WIDTH (DW),
        .NUM_CH     (NCH),
        .WIDTH      (W),
        .HEIGHT     (H),
        .NUM_IMG    (NIMG),
        .NUM_PASS   (NPASS),
        .GAP        (GAPC),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .mem_rd_en (mem_rd_en),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .data_out  (data_out),
        .valid_out (valid_out),
        .ready_in  (ready_in),
        .sof       (sof),
        .eol       (eol),
        .eof       (eof),
        .busy      (busy),
        .done      (done)
    );

    task automatic check(input string tag, input logic [95:0] observed, input logic [95:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Expected {sof, eol, eof, data} for the idx-th transferred beat of a run
    function automatic logic [66:0] exp_beat(input int idx);
        int a;
        int p;
        a = idx % PASS_PIX;
        p = a % FRAME;
        return {(p == 0), (p % W == W - 1), (p == FRAME - 1), 32'(a + 100), 32'(a)};
    endfunction

    // mode 0: ready always high; mode 1: random ready with a 10-cycle stall window
    task automatic start_and_run(input int mode, input int start_again_at);
        int idx = 0;
        int issued = 0;
        int cyc = 0;
        int bubbles = 0;
        int eofs = 0;
        int dones = 0;
        int first_valid = -1;
        bit stalled = 1'b0;
        bit finished = 1'b0;
        logic [66:0] prev_beat = '0;
        start    = 1'b1;
        ready_in = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("start_busy", busy, 1'b1);
        check("start_rd_en_addr", {mem_rd_en, mem_addr}, {1'b1, 5'd0});
        check("start_valid_low", valid_out, 1'b0);
        while (!finished && cyc < 1000) begin
            if (mode == 1) begin
                ready_in = (cyc >= 20 && cyc < 30) ? 1'b0 : 1'($urandom_range(0, 1));
            end else begin
                ready_in = 1'b1;
            end
            start = (cyc == start_again_at);
            @(negedge clk);
            if (idx == TOTAL) begin
                check("done_pulse_busy_low", {done, busy}, 2'b10);
                finished = 1'b1;
            end else begin
                if (done) dones++;
                if (stalled) check("stall_hold", {valid_out, sof, eol, eof, data_out}, {1'b1, prev_beat});
                check("outstanding_le2", (issued - idx <= 2), 1'b1);
                if (mem_rd_en) begin
                    check("rd_addr", mem_addr, issued % PASS_PIX);
                    issued++;
                end
                if (valid_out) begin
                    if (first_valid < 0) first_valid = cyc;
                    if (mode == 0 && idx > 0) check("bubbles", bubbles, (idx % FRAME == 0) ? GAPC : 0);
                    bubbles = 0;
                    check("beat", {sof, eol, eof, data_out}, exp_beat(idx));
                    prev_beat = {sof, eol, eof, data_out};
                    stalled   = !ready_in;
                    if (ready_in) begin
                        if (eof) eofs++;
                        idx++;
                    end
                end else begin
                    bubbles++;
                    stalled = 1'b0;
                end
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        start    = 1'b0;
        ready_in = 1'b1;
        check("run_complete", finished, 1'b1);
        check("beat_count", idx, TOTAL);
        check("eof_count", eofs, 4);
        check("no_early_done", dones, 0);
        check("first_valid_latency", first_valid, 2);
        repeat (4) begin
            @(negedge clk);
            check("post_idle", {valid_out, done, busy, mem_rd_en}, 4'b0000);
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        bit found;
        reset    = 1'b1;
        start    = 1'b0;
        ready_in = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_ctrl", {mem_rd_en, valid_out, busy, done}, 4'b0000);
        check("reset_flags", {sof, eol, eof}, 3'b000);
        check("reset_addr", mem_addr, 5'd0);
        check("reset_data", data_out, 64'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("idle_no_read", {mem_rd_en, busy}, 2'b00);

        // Full run: frames, passes and gaps at full rate
        start_and_run(0, -1);

        // Backpressure run
        start_and_run(1, -1);

        // Reset while beat 7 is on the output and a read is outstanding
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (valid_out && data_out[31:0] == 32'd7) begin
                found = 1'b1;
            end else begin
                @(posedge clk);
                #1;
            end
        end
        check("reached_beat7", found, 1'b1);
        check("beat7_read_pending", mem_rd_en, 1'b1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("rst_mid_ctrl", {mem_rd_en, valid_out, busy, done, sof, eol, eof}, 7'd0);
        check("rst_mid_addr", mem_addr, 5'd0);
        check("rst_mid_data", data_out, 64'd0);
        repeat (3) begin
            @(negedge clk);
            check("no_stale_beat", valid_out, 1'b0);
            @(posedge clk);
            #1;
        end

        // Restart after reset, then a run with a start pulse while busy
        start_and_run(0, -1);
        start_and_run(0, 10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
